mem_port_arbiter: RTL

Shares the single byte-addressable data memory between the processor's instruction-fetch port and its load/store port. Arbitrates between the two ports and performs alignment checking. Generates per-byte write lanes and extracts sized, extended read data, so the control FSM issues plain requests and waits for an acknowledge. It sits between the processor control/datapath and the memory macro.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/lsu_lane_align.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state and access-size encodings for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane alignment: misalign detect, write strobes/data, read shift and extend
module lsu_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        misaligned,
    output logic [3:0]  wr_strb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;

    always_comb begin
        misaligned = 1'b0;
        wr_strb    = 4'h0;
        wdata_lane = wdata << {off, 3'b000};
        rshift     = rdata >> {off, 3'b000};
        rdata_ext  = rshift;
        case (size)
            SIZE_B: begin
                wr_strb   = 4'b0001 << off;
                rdata_ext = {{24{rshift[7] & ~is_unsigned}}, rshift[7:0]};
            end
            SIZE_H: begin
                misaligned = off[0];
                wr_strb    = 4'b0011 << off;
                rdata_ext  = {{16{rshift[15] & ~is_unsigned}}, rshift[15:0]};
            end
            SIZE_W: begin
                misaligned = (off != 2'b00);
                wr_strb    = 4'hF;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for the shared data memory; MEM_ARB_ROUND_ROBIN_EN selects round-robin grant
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    output logic          i_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic          d_unsigned,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_wr_en,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    state_t          state;
    logic            sel_d;
    logic            l_we;
    logic            l_uns;
    logic [1:0]      l_size;
    logic [AW-1:0]   l_addr;
    logic [CW-1:0]   cnt;

    logic            grant_d;
    logic [AW-1:0]   c_addr;
    logic [1:0]      c_size;
    logic            c_we;
    logic [1:0]      a_off;
    logic [1:0]      a_size;
    logic            a_uns;
    logic            mis;
    logic [3:0]      strb;
    logic [31:0]     wlane;
    logic [31:0]     rext;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d;

    assign grant_d = d_req && (!i_req || !last_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (state == IDLE && (i_req || d_req)) begin
            last_d <= grant_d;
        end
    end
`else
    assign grant_d = d_req;
`endif

    assign c_addr = grant_d ? d_addr : i_addr;
    assign c_size = grant_d ? d_size : SIZE_W;
    assign c_we   = grant_d & d_we;

    // In IDLE the aligner judges the candidate request; afterwards it works on the latched one.
    assign a_off  = (state == IDLE) ? c_addr[1:0] : l_addr[1:0];
    assign a_size = (state == IDLE) ? c_size      : l_size;
    assign a_uns  = (state == IDLE) ? d_unsigned  : l_uns;

    lsu_lane_align u_align (
        .off         (a_off),
        .size        (a_size),
        .is_unsigned (a_uns),
        .wdata       (d_wdata),
        .rdata       (mem_rdata),
        .misaligned  (mis),
        .wr_strb     (strb),
        .wdata_lane  (wlane),
        .rdata_ext   (rext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sel_d     <= 1'b0;
            l_we      <= 1'b0;
            l_uns     <= 1'b0;
            l_size    <= SIZE_W;
            l_addr    <= '0;
            cnt       <= '0;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
            mem_addr  <= '0;
            mem_wr_en <= 4'h0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        sel_d  <= grant_d;
                        l_we   <= c_we;
                        l_uns  <= d_unsigned;
                        l_size <= c_size;
                        l_addr <= c_addr;
                        busy   <= 1'b1;
                        if (mis) begin
                            state <= RESP;
                            if (grant_d) begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                i_ack   <= 1'b1;
                                i_err   <= 1'b1;
                                i_rdata <= '0;
                            end
                        end else begin
                            state     <= ISSUE;
                            mem_addr  <= {c_addr[AW-1:2], 2'b00};
                            mem_wr_en <= c_we ? strb : 4'h0;
                            mem_wdata <= wlane;
                        end
                    end
                end
                ISSUE: begin
                    mem_wr_en <= 4'h0;
                    cnt       <= CNT_INIT;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= RESP;
                        if (sel_d) begin
                            d_ack   <= 1'b1;
                            d_err   <= 1'b0;
                            d_rdata <= l_we ? '0 : rext;
                        end else begin
                            i_ack   <= 1'b1;
                            i_err   <= 1'b0;
                            i_rdata <= rext;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
